// File: rtl/psg_write_arbiter.sv
// Shares the PSG register write port between host CPU (A) and sequencer (B),
// paces addr/data/wr_n cycles, runs a mute sequence and keeps a readable shadow.
module psg_write_arbiter #(
   parameter int         WR_LOW_CYCLES = 2,
   parameter int         WR_GAP_CYCLES = 4,
   parameter logic [7:0] MUTE_MIXER    = 8'h3F
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_valid,
   output logic       a_ready,
   input  logic [3:0] a_addr,
   input  logic [7:0] a_data,
   input  logic       b_valid,
   output logic       b_ready,
   input  logic [3:0] b_addr,
   input  logic [7:0] b_data,
   input  logic       mute_req,
   output logic       mute_busy,
   output logic       busy,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [3:0] psg_addr,
   output logic [7:0] psg_data,
   output logic       psg_wr_n
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

   localparam logic [3:0] LOW_LAST = 4'(WR_LOW_CYCLES - 1);
   localparam logic [3:0] GAP_LAST = 4'((WR_GAP_CYCLES == 0) ? 0 : WR_GAP_CYCLES - 1);

   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic       last_grant_b;
   logic       mute_pending;
   logic [1:0] mute_idx;
   logic       mute_last;
   logic       grant_a, grant_b, issue_mute, done;
   logic [3:0] wr_addr_nx;
   logic [7:0] wr_data_nx;
   logic [7:0] shadow [16];

   assign a_ready = grant_a & reset;
   assign b_ready = grant_b & reset;
   assign busy    = (state != IDLE) | mute_pending | mute_busy;

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      issue_mute = 1'b0;
      done       = 1'b0;
      wr_addr_nx = psg_addr;
      wr_data_nx = psg_data;
      case (state)
         IDLE: begin
            // mute_busy also covers mute_pending, so ports stay blocked for the whole sequence
            if (mute_busy) begin
               issue_mute = 1'b1;
               wr_addr_nx = 4'd7 + {2'b00, mute_idx};
               wr_data_nx = (mute_idx == 2'd0) ? MUTE_MIXER : 8'h00;
               state_nx   = SETUP;
            end else if (a_valid && (!b_valid || last_grant_b)) begin
               grant_a    = 1'b1;
               wr_addr_nx = a_addr;
               wr_data_nx = a_data;
               state_nx   = SETUP;
            end else if (b_valid) begin
               grant_b    = 1'b1;
               wr_addr_nx = b_addr;
               wr_data_nx = b_data;
               state_nx   = SETUP;
            end
         end
         SETUP: begin
            state_nx = STROBE;
            cnt_nx   = 4'd0;
         end
         STROBE: begin
            if (cnt == LOW_LAST) begin
               cnt_nx = 4'd0;
               if (WR_GAP_CYCLES == 0) begin
                  state_nx = IDLE;
                  done     = 1'b1;
               end else begin
                  state_nx = GAP;
               end
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_nx = IDLE;
               done     = 1'b1;
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         last_grant_b <= 1'b1;
         mute_pending <= 1'b0;
         mute_busy    <= 1'b0;
         mute_idx     <= 2'd0;
         mute_last    <= 1'b0;
         psg_addr     <= 4'd0;
         psg_data     <= 8'h00;
         psg_wr_n     <= 1'b1;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         psg_addr <= wr_addr_nx;
         psg_data <= wr_data_nx;
         psg_wr_n <= (state_nx != STROBE);
         if (grant_a)
            last_grant_b <= 1'b0;
         else if (grant_b)
            last_grant_b <= 1'b1;
         if (issue_mute) begin
            mute_pending <= 1'b0;
            mute_idx     <= mute_idx + 2'd1;
            mute_last    <= (mute_idx == 2'd3);
         end
         if (mute_req && !mute_busy) begin
            mute_pending <= 1'b1;
            mute_busy    <= 1'b1;
         end else if (done && mute_last) begin
            mute_busy <= 1'b0;
            mute_last <= 1'b0;
         end
      end
   end

   // Shadow captures on the first STROBE cycle; a same-cycle read returns the old value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) shadow[i] <= 8'h00;
         rd_data <= 8'h00;
      end else begin
         rd_data <= shadow[rd_addr];
         if (state == STROBE && cnt == 4'd0)
            shadow[psg_addr] <= psg_data;
      end
   end

endmodule

// File: tb/tb_psg_write_arbiter.sv
// Bench for psg_write_arbiter: two instances (default pacing and WR_LOW=1/WR_GAP=0)
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_psg_write_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       a_valid = 1'b0, b_valid = 1'b0, mute_req = 1'b0;
   logic [3:0] a_addr = 4'd0, b_addr = 4'd0, rd_addr = 4'd0;
   logic [7:0] a_data = 8'h00, b_data = 8'h00;

   logic       ar_o [2];
   logic       br_o [2];
   logic       mb_o [2];
   logic       bz_o [2];
   logic       wn_o [2];
   logic [3:0] pa_o [2];
   logic [7:0] pd_o [2];
   logic [7:0] rd_o [2];

   psg_write_arbiter dut0 (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(ar_o[0]), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(br_o[0]), .b_addr(b_addr), .b_data(b_data),
      .mute_req(mute_req), .mute_busy(mb_o[0]), .busy(bz_o[0]),
      .rd_addr(rd_addr), .rd_data(rd_o[0]),
      .psg_addr(pa_o[0]), .psg_data(pd_o[0]), .psg_wr_n(wn_o[0])
   );

   psg_write_arbiter #(.WR_LOW_CYCLES(1), .WR_GAP_CYCLES(0)) dut1 (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_ready(ar_o[1]), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(br_o[1]), .b_addr(b_addr), .b_data(b_data),
      .mute_req(mute_req), .mute_busy(mb_o[1]), .busy(bz_o[1]),
      .rd_addr(rd_addr), .rd_data(rd_o[1]),
      .psg_addr(pa_o[1]), .psg_data(pd_o[1]), .psg_wr_n(wn_o[1])
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // model state per instance: age = cycles since the current write was issued
   int         m_age [2];
   bit         m_lgb [2];
   bit         m_mb  [2];
   int         m_idx [2];
   bit         m_last[2];
   logic [3:0] m_pa  [2];
   logic [7:0] m_pd  [2];
   logic [7:0] m_rd  [2];
   logic [7:0] m_sh  [2][16];

   logic       s_ar[2], s_br[2], s_wn[2], s_mb[2];
   logic [7:0] s_rd[2];
   logic [3:0] s_pa[2];
   logic [7:0] s_pd[2];
   logic       prev_wn[2];
   int         lq0[$], lq1[$], lc0[$];

   function automatic int lw(int k); return (k == 0) ? 2 : 1; endfunction
   function automatic int gw(int k); return (k == 0) ? 4 : 0; endfunction

   task automatic chk(string nm, int k, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, k, cyc, act, exp);
      end
   endtask

   task automatic timeout(string nm);
      total++;
      bad++;
      $display("FAIL timeout %s cyc=%0d got=expired want=event", nm, cyc);
   endtask

   task automatic mreset(int k);
      m_age[k] = 100; m_lgb[k] = 1'b1; m_mb[k] = 1'b0; m_idx[k] = 0; m_last[k] = 1'b0;
      m_pa[k] = 4'd0; m_pd[k] = 8'h00; m_rd[k] = 8'h00;
      for (int i = 0; i < 16; i++) m_sh[k][i] = 8'h00;
   endtask

   task automatic mstep(int k, bit free, bit ea, bit eb);
      bit   mb_nx;
      logic [7:0] nrd;
      nrd = m_sh[k][rd_addr];
      if (m_age[k] == 2) m_sh[k][m_pa[k]] = m_pd[k];
      m_rd[k] = nrd;
      mb_nx = m_mb[k];
      if (mute_req && !m_mb[k]) mb_nx = 1'b1;
      if (m_age[k] == 1 + lw(k) + gw(k) && m_last[k]) begin
         mb_nx = 1'b0;
         m_last[k] = 1'b0;
      end
      if (free && m_mb[k]) begin
         m_pa[k] = 4'(7 + m_idx[k]);
         m_pd[k] = (m_idx[k] == 0) ? 8'h3F : 8'h00;
         m_last[k] = (m_idx[k] == 3);
         m_idx[k] = (m_idx[k] + 1) % 4;
         m_age[k] = 1;
      end else if (ea) begin
         m_pa[k] = a_addr; m_pd[k] = a_data; m_lgb[k] = 1'b0; m_age[k] = 1;
      end else if (eb) begin
         m_pa[k] = b_addr; m_pd[k] = b_data; m_lgb[k] = 1'b1; m_age[k] = 1;
      end else if (m_age[k] < 100) begin
         m_age[k]++;
      end
      m_mb[k] = mb_nx;
   endtask

   // one clock: compare at the falling edge, advance the model, return just after the rising edge
   task automatic tick();
      bit free, ea, eb, ewn, ebz;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!reset) mreset(k);
         free = (m_age[k] >= 2 + lw(k) + gw(k));
         ea   = reset && free && !m_mb[k] && a_valid && (!b_valid || m_lgb[k]);
         eb   = reset && free && !m_mb[k] && b_valid && (!a_valid || !m_lgb[k]);
         ewn  = !(m_age[k] >= 2 && m_age[k] <= 1 + lw(k));
         ebz  = !free || m_mb[k];
         chk("a_ready",   k, ar_o[k], ea);
         chk("b_ready",   k, br_o[k], eb);
         chk("psg_wr_n",  k, wn_o[k], ewn);
         chk("psg_addr",  k, pa_o[k], m_pa[k]);
         chk("psg_data",  k, pd_o[k], m_pd[k]);
         chk("rd_data",   k, rd_o[k], m_rd[k]);
         chk("mute_busy", k, mb_o[k], m_mb[k]);
         chk("busy",      k, bz_o[k], ebz);
         s_ar[k] = ar_o[k]; s_br[k] = br_o[k]; s_wn[k] = wn_o[k]; s_mb[k] = mb_o[k];
         s_rd[k] = rd_o[k]; s_pa[k] = pa_o[k]; s_pd[k] = pd_o[k];
         if (prev_wn[k] && !wn_o[k]) begin
            if (k == 0) begin lq0.push_back(pa_o[0] * 256 + pd_o[0]); lc0.push_back(cyc); end
            else lq1.push_back(pa_o[1] * 256 + pd_o[1]);
         end
         prev_wn[k] = wn_o[k];
         if (reset) mstep(k, free, ea, eb);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; mute_req = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      lq0.delete(); lq1.delete(); lc0.delete();
   endtask

   function automatic int logat(int i);
      return (i < lq0.size()) ? lq0[i] : -1;
   endfunction

   task automatic wait_mute_done(string nm);
      bit seen, ok;
      seen = 1'b0; ok = 1'b0;
      for (int i = 0; i < 150; i++) begin
         tick();
         if (s_mb[0]) seen = 1'b1;
         else if (seen) begin ok = 1'b1; break; end
      end
      if (!ok) timeout(nm);
   endtask

   initial begin
      logic h_ar[2][9];
      logic h_wn[2][9];
      logic [3:0] h_pa[9];
      logic [7:0] h_pd[9];
      logic [7:0] h_rd;
      int ai, bi, viol;
      bit got;
      prev_wn[0] = 1'b1; prev_wn[1] = 1'b1;
      mreset(0); mreset(1);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      do_reset();
      chk("reset_wr_n", 0, s_wn[0], 1);
      chk("reset_rd",   0, s_rd[0], 0);
      chk("reset_mb",   0, s_mb[0], 0);

      // single A write right after reset release, held valid for nine cycles
      a_valid = 1'b1; a_addr = 4'd7; a_data = 8'h38; rd_addr = 4'd7;
      for (int c = 0; c < 9; c++) begin
         tick();
         for (int k = 0; k < 2; k++) begin h_ar[k][c] = s_ar[k]; h_wn[k][c] = s_wn[k]; end
         h_pa[c] = s_pa[0]; h_pd[c] = s_pd[0];
      end
      a_valid = 1'b0;
      repeat (4) tick();
      h_rd = s_rd[0];
      chk("acc_c0", 0, h_ar[0][0], 1);
      chk("acc_c4", 0, h_ar[0][4], 0);
      chk("acc_c7", 0, h_ar[0][7], 0);
      chk("acc_c8", 0, h_ar[0][8], 1);
      chk("addr_c1", 0, h_pa[1], 7);
      chk("data_c1", 0, h_pd[1], 8'h38);
      chk("wrn_c1", 0, h_wn[0][1], 1);
      chk("wrn_c2", 0, h_wn[0][2], 0);
      chk("wrn_c3", 0, h_wn[0][3], 0);
      chk("wrn_c4", 0, h_wn[0][4], 1);
      chk("shadow7", 0, h_rd, 8'h38);
      for (int c = 0; c < 9; c++) chk("fast_acc", 1, h_ar[1][c], (c % 3 == 0 && c <= 6) ? 1 : 0);
      chk("fast_wrn_c2", 1, h_wn[1][2], 0);
      chk("fast_wrn_c3", 1, h_wn[1][3], 1);
      chk("fast_wrn_c5", 1, h_wn[1][5], 0);

      // both ports continuously valid: grants alternate starting with A
      do_reset();
      ai = 0; bi = 0; viol = 0; got = 1'b0;
      for (int i = 0; i < 80; i++) begin
         a_valid = (ai < 2); a_addr = 4'(ai); a_data = 8'(ai + 1);
         b_valid = (bi < 2); b_addr = 4'(bi + 2); b_data = 8'(bi + 3);
         if (ai == 2 && bi == 2) begin got = 1'b1; break; end
         tick();
         if (s_ar[0] && s_br[0]) viol++;
         if (s_ar[0]) ai++;
         if (s_br[0]) bi++;
      end
      if (!got) timeout("fairness");
      repeat (10) tick();
      chk("both_ready", 0, viol, 0);
      chk("order0", 0, logat(0), 16'h0001);
      chk("order1", 0, logat(1), 16'h0203);
      chk("order2", 0, logat(2), 16'h0102);
      chk("order3", 0, logat(3), 16'h0304);
      for (int i = 0; i + 1 < lc0.size(); i++) chk("spacing", 0, lc0[i + 1] - lc0[i], 8);

      // mute requested during the strobe of a B write, A waiting behind it
      do_reset();
      b_valid = 1'b1; b_addr = 4'd8; b_data = 8'h0F;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s_br[0]) begin got = 1'b1; break; end
      end
      if (!got) timeout("b_accept");
      b_valid = 1'b0;
      tick();
      mute_req = 1'b1; a_valid = 1'b1; a_addr = 4'd1; a_data = 8'h55;
      tick();
      mute_req = 1'b0;
      viol = 0;
      begin
         bit seen, ok;
         seen = 1'b0; ok = 1'b0;
         for (int i = 0; i < 150; i++) begin
            tick();
            if (s_ar[0] && s_mb[0]) viol++;
            if (s_mb[0]) seen = 1'b1;
            else if (seen) begin ok = 1'b1; break; end
         end
         if (!ok) timeout("mute_end");
      end
      a_valid = 1'b0;
      repeat (10) tick();
      rd_addr = 4'd8;
      repeat (2) tick();
      chk("a_during_mute", 0, viol, 0);
      chk("shadow8", 0, s_rd[0], 0);
      chk("mute_log0", 0, logat(0), 16'h080F);
      chk("mute_log1", 0, logat(1), 16'h073F);
      chk("mute_log2", 0, logat(2), 16'h0800);
      chk("mute_log3", 0, logat(3), 16'h0900);
      chk("mute_log4", 0, logat(4), 16'h0A00);
      chk("mute_log5", 0, logat(5), 16'h0155);

      // reset asserted in the first strobe cycle of an A write
      do_reset();
      a_valid = 1'b1; a_addr = 4'd5; a_data = 8'hAA;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (s_ar[0]) begin got = 1'b1; break; end
      end
      if (!got) timeout("a_accept");
      a_valid = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      chk("async_wr_n", 0, wn_o[0], 1);
      chk("async_addr", 0, pa_o[0], 0);
      tick();
      reset = 1'b1; rd_addr = 4'd5;
      lq0.delete(); lq1.delete(); lc0.delete();
      repeat (2) tick();
      chk("shadow5", 0, s_rd[0], 0);
      a_valid = 1'b1; a_addr = 4'd6; a_data = 8'h11;
      tick();
      a_valid = 1'b0;
      repeat (10) tick();
      chk("post_reset_wr", 0, logat(0), 16'h0611);

      // two mute pulses three cycles apart produce a single sequence
      do_reset();
      mute_req = 1'b1; tick(); mute_req = 1'b0;
      repeat (2) tick();
      mute_req = 1'b1; tick(); mute_req = 1'b0;
      wait_mute_done("double_mute");
      repeat (4) tick();
      chk("mute_count0", 0, lq0.size(), 4);
      chk("mute_count1", 1, lq1.size(), 4);

      // randomized traffic against the model
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         a_valid  = ($urandom_range(0, 2) != 0);
         b_valid  = ($urandom_range(0, 2) != 0);
         a_addr   = 4'($urandom_range(0, 15));
         b_addr   = 4'($urandom_range(0, 15));
         a_data   = 8'($urandom_range(0, 255));
         b_data   = 8'($urandom_range(0, 255));
         rd_addr  = 4'($urandom_range(0, 15));
         mute_req = ($urandom_range(0, 39) == 0);
         reset    = ($urandom_range(0, 299) != 0);
         tick();
      end
      reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0; mute_req = 1'b0;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/psg_write_arbiter.md
Name: psg_write_arbiter

Overview:
- Sequences and shares the YM2149/BHG_jt49 PSG register write port between two requesters: host CPU (port A) and the music/DMA sequencer (port B).
- Round-robin arbitrates single-register writes and generates correctly paced addr/data/wr_n cycles for the PSG.
- Issues a hardware mute sequence on request.
- Keeps a 16-entry shadow of the last values written, readable without disturbing the PSG.

Parameters:
- WR_LOW_CYCLES, 2, number of clk cycles psg_wr_n is held low per write (1..15).
- WR_GAP_CYCLES, 4, number of idle clk cycles after psg_wr_n rises before the next write may start (0..15).
- MUTE_MIXER, 8'h3F, value written to register 7 during the mute sequence.

Ports:
- clk  in  1  system clock; same clock as the PSG.
- reset  in  1  asynchronous, active-low reset.
- a_valid  in  1  port A write request.
- a_ready  out  1  port A accept; a transfer occurs when a_valid & a_ready.
- a_addr  in  4  port A register address.
- a_data  in  8  port A register data.
- b_valid  in  1  port B write request.
- b_ready  out  1  port B accept.
- b_addr  in  4  port B register address.
- b_data  in  8  port B register data.
- mute_req  in  1  single-cycle pulse requesting the mute sequence.
- mute_busy  out  1  high from mute_req acceptance until the last mute write's gap ends.
- busy  out  1  high whenever state != IDLE or mute is pending.
- rd_addr  in  4  shadow readback address.
- rd_data  out  8  shadow[rd_addr], registered, 1-cycle latency.
- psg_addr  out  4  to PSG addr.
- psg_data  out  8  to PSG data.
- psg_wr_n  out  1  to PSG wr_n; active low.

Behaviour:
- Reset values (async, while reset=0):
  - psg_addr=0, psg_data=0, psg_wr_n=1, rd_data=0.
  - All 16 shadow entries = 0.
  - state=IDLE, mute_pending=0, mute_busy=0, busy=0.
  - last_grant=B, so A wins the first tie.
  - a_ready/b_ready are forced 0 while reset=0.
- Reset asserted mid-write: psg_wr_n returns to 1 immediately (asynchronously); the in-flight write is abandoned and the shadow is not updated for it.
- States: IDLE, SETUP, STROBE, GAP.
- Grant (combinational, in IDLE only, and only when mute_pending=0):
  - Only A valid -> A. Only B valid -> B.
  - Both valid -> the port that is not last_grant.
  - a_ready = grant_A; b_ready = grant_B. At most one ready is high per cycle. Both readys are 0 in every state other than IDLE.
- Accept cycle t:
  - Latch the granted addr/data; last_grant <= granted port; go to SETUP.
  - Cycle t+1 (SETUP): psg_addr/psg_data drive the latched values; psg_wr_n=1.
  - Cycles t+2 .. t+1+WR_LOW_CYCLES (STROBE): psg_wr_n=0; addr/data stable.
  - Then WR_GAP_CYCLES cycles in GAP with psg_wr_n=1. If WR_GAP_CYCLES=0, go straight to IDLE.
  - Earliest next accept is cycle t+2+WR_LOW_CYCLES+WR_GAP_CYCLES. With defaults that is t+8, a throughput of 1 write per 8 clk.
- psg_addr/psg_data hold their last values in IDLE; they do not return to 0.
- Shadow update: shadow[addr] <= data on the first STROBE cycle of each write, including mute writes.
- Readback:
  - rd_data <= shadow[rd_addr] every cycle.
  - If rd_addr hits the entry being written in the same cycle, rd_data returns the old value; the new value is visible on the next cycle.
- Mute:
  - mute_req=1 while mute_busy=0 sets mute_pending and mute_busy in the next cycle.
  - mute_req while mute_busy=1 is ignored.
  - A write already in progress completes first.
  - From IDLE with mute_pending, 4 writes are issued back-to-back with normal SETUP/STROBE/GAP timing: R7=MUTE_MIXER, R8=0, R9=0, R10=0. Neither port is granted during the sequence.
  - mute_pending clears when the R7 write enters SETUP.
  - mute_busy clears at the end of the R10 GAP, as the block returns to IDLE.
  - mute_req arriving in the same cycle as a port accept: the accept wins; mute runs after that write.
- Arbitration fairness: with both ports continuously valid, grants strictly alternate A, B, A, B.

Test Plan:
- Reset release, a_valid=1, a_addr=7, a_data=8'h38 -> a_ready=1 in cycle 0; psg_addr=7/psg_data=8'h38 in cycle 1; psg_wr_n=0 in cycles 2-3; next a_ready no earlier than cycle 8; shadow[7]=8'h38 (rd_addr=7 -> rd_data=8'h38).
- a_valid and b_valid held high; A writes R0=1,R1=2; B writes R2=3,R3=4 -> PSG write order R0,R2,R1,R3 at 8-cycle spacing; a_ready and b_ready never high together.
- mute_req pulsed during STROBE of a B write R8=8'h0F -> B write completes; then R7=8'h3F, R8=0, R9=0, R10=0; a_valid held high is not accepted until mute_busy falls; shadow[8]=0 afterwards.
- reset driven low in the first STROBE cycle of A write R5=8'hAA -> psg_wr_n=1 immediately; shadow[5]=0; psg_addr=0; after release, next write proceeds normally.
- Parameters WR_LOW_CYCLES=1, WR_GAP_CYCLES=0 with back-to-back A writes -> psg_wr_n low for 1 cycle per write, accepts every 3 cycles.
- mute_req pulsed twice 3 cycles apart -> exactly 4 mute writes total.
